ascon_byte_io: RTL and testbench
================================

Name: ascon_byte_io

Overview:
- Byte-serial front end for the 320-bit Ascon state in the TinyTapeout top.
- Loads 40 bytes from the 8-bit input pins into the state and launches the permutation core with a one-cycle start pulse.
- Captures the permuted state, then streams it back out as 40 bytes.
- Uses valid/ready handshakes on both byte streams.

Parameters:
- NUM_BYTES, 40, bytes per state transfer; fixed to STATE_W/8.
- STATE_W, 320, state width in bits (S_0..S_4, 64 bits each).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  incoming state byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a byte this cycle
- out_data  output  8  outgoing state byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data this cycle
- perm_start  output  1  one-cycle pulse; permutation starts on state_to_perm
- perm_done  input  1  one-cycle pulse; state_from_perm is valid this cycle
- state_to_perm  output  STATE_W  loaded state, {S_0,S_1,S_2,S_3,S_4}, S_0 in MSBs
- state_from_perm  input  STATE_W  permuted state, same packing
- busy  output  1  high in any state other than LOAD, or in LOAD with cnt>0

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=LOAD, cnt=0, shift register=0, state_to_perm=0, in_ready=1, out_valid=0, perm_start=0, busy=0. out_data reflects the zeroed shift register (0x00).
- Byte order is big-endian. The first byte in goes to bits [319:312] (MSB of S_0). The first byte out is bits [319:312] of the captured result.
- FSM states: LOAD, START, WAIT, UNLOAD. cnt is a 6-bit counter, 0..NUM_BYTES-1.
- LOAD:
  - in_ready=1.
  - On in_valid & in_ready: shift register <= {shift[311:0], in_data}; cnt++.
  - On the beat with cnt==39: cnt<=0, copy the completed value (including this byte) to state_to_perm, go to START.
- START:
  - perm_start=1 for exactly this one cycle; in_ready=0.
  - Next state is WAIT.
- WAIT:
  - in_ready=0; out_valid=0.
  - On perm_done: shift register <= state_from_perm, go to UNLOAD.
  - perm_done seen in any other state is ignored.
- UNLOAD:
  - out_valid=1; out_data=shift[319:312].
  - On out_valid & out_ready: shift <= {shift[311:0], 8'h00}; cnt++.
  - On the beat with cnt==39: cnt<=0, out_valid drops next cycle, go to LOAD.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- in_valid is ignored outside LOAD. No byte is ever dropped or duplicated.
- state_to_perm holds its value from the START entry until the next 40th load beat, so the core may sample it at any point during WAIT.
- Throughput: one byte per cycle on each side.
  - Latency from the 40th load beat to perm_start: 1 cycle.
  - From perm_done to the first out_valid: 1 cycle.
- Reset mid-operation (any state, any cnt) returns immediately to the reset values. A partial load is discarded; a pending permutation result is discarded.
- perm_done arriving in the same cycle START is active cannot occur (the core needs at least one cycle); no special handling is required.

Test Plan:
- Reset: assert rst_n=0 mid-LOAD with cnt=17 -> in_ready=1, busy=0, cnt=0, out_valid=0. A fresh 40-byte load then completes normally.
- Load ordering: send bytes 0x00..0x27 with in_valid held high -> perm_start pulses once, the cycle after byte 0x27. state_to_perm[319:312]=0x00, [7:0]=0x27.
- Loopback: model the core as perm_done=1 three cycles after perm_start, with state_from_perm = state_to_perm XOR {40{8'hA5}} -> out bytes are 0xA5,0xA4,...,0x82 in order, exactly 40 beats, then back in LOAD.
- Output backpressure: toggle out_ready pseudo-randomly (about 50%) -> out_data stable while stalled; all 40 bytes match the expected sequence with no gaps or repeats.
- Input bubbles and stray signals: in_valid toggling with gaps; perm_done pulsed during LOAD; in_valid=1 during WAIT and UNLOAD -> exactly 40 bytes are accepted; no extra perm_start; the stray perm_done is ignored.
- Back-to-back transfers: two full load/permute/unload transactions with no idle cycles between them -> the second load is accepted starting the cycle after the 40th output beat, and both results are correct.

Source files
------------

// File: rtl/ascon_byte_io.sv
// Byte-serial load/unload front end for the 320-bit Ascon state.
// Bytes shift in MSB-first, the permutation is started, and its result is shifted back out MSB-first.
module ascon_byte_io #(
    parameter int STATE_W   = 320,
    parameter int NUM_BYTES = STATE_W / 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               perm_start,
    input  logic               perm_done,
    output logic [STATE_W-1:0] state_to_perm,
    input  logic [STATE_W-1:0] state_from_perm,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } state_e;

    localparam logic [5:0] LAST_CNT = 6'(NUM_BYTES - 1);

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [STATE_W-1:0] shift_q, shift_d;
    logic [STATE_W-1:0] perm_q, perm_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            shift_q <= '0;
            perm_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            perm_q  <= perm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        perm_d  = perm_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    shift_d = {shift_q[STATE_W-9:0], in_data};
                    if (cnt_q == LAST_CNT) begin
                        // perm_q is the stable copy the core reads; shift_q is reused for the result.
                        cnt_d   = '0;
                        perm_d  = {shift_q[STATE_W-9:0], in_data};
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (perm_done) begin
                    shift_d = state_from_perm;
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    shift_d = {shift_q[STATE_W-9:0], 8'h00};
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    assign in_ready      = (state_q == ST_LOAD);
    assign out_valid     = (state_q == ST_UNLOAD);
    assign perm_start    = (state_q == ST_START);
    assign out_data      = shift_q[STATE_W-1:STATE_W-8];
    assign state_to_perm = perm_q;
    assign busy          = (state_q != ST_LOAD) || (cnt_q != 6'd0);

endmodule

// File: tb/tb_ascon_byte_io.sv
// Randomized bench for ascon_byte_io: a fake permutation core XORs the state with a mask,
// and every output byte is predicted from the input bytes and mask.
module tb_ascon_byte_io;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         perm_start;
    logic         perm_done;
    logic [319:0] state_to_perm;
    logic [319:0] state_from_perm;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   tx_bytes   [40];
    logic [7:0]   mask_bytes [40];
    logic [319:0] mask_vec;
    logic [2:0]   ps_pipe;
    logic         stray_done;
    int           start_count;

    always #5 clk = ~clk;

    ascon_byte_io dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .perm_start      (perm_start),
        .perm_done       (perm_done),
        .state_to_perm   (state_to_perm),
        .state_from_perm (state_from_perm),
        .busy            (busy)
    );

    // Fake core: done pulse three cycles after start, result = input XOR mask.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_pipe     <= '0;
            start_count <= 0;
        end else begin
            ps_pipe <= {ps_pipe[1:0], perm_start};
            if (perm_start) start_count <= start_count + 1;
        end
    end
    assign perm_done       = ps_pipe[2] | stray_done;
    assign state_from_perm = state_to_perm ^ mask_vec;

    task automatic set_mask(input bit use_a5);
        for (int i = 0; i < 40; i++) begin
            mask_bytes[i] = use_a5 ? 8'hA5 : 8'($urandom);
            mask_vec[319-8*i -: 8] = mask_bytes[i];
        end
    endtask

    task automatic set_tx(input bit ramp);
        for (int i = 0; i < 40; i++) tx_bytes[i] = ramp ? 8'(i) : 8'($urandom);
    endtask

    // Called at a negedge; returns at the negedge right after the 40th accepted byte.
    task automatic send_bytes(input int valid_pct, input bit stray, input bit hold);
        int idx;
        int cyc;
        int starts0;
        bit acc;
        logic [319:0] exp_stp;
        idx = 0;
        cyc = 0;
        starts0 = start_count;
        while (idx < 40 && cyc < 400) begin
            in_valid   = ($urandom_range(99) < valid_pct);
            in_data    = in_valid ? tx_bytes[idx] : 8'($urandom);
            stray_done = stray && (cyc == 5 || cyc == 20);
            acc        = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            cyc++;
        end
        stray_done = 1'b0;
        in_valid   = hold;
        in_data    = 8'($urandom);
        checks++;
        if (idx != 40) begin
            failures++;
            $display("FAIL load_timeout accepted=%0d required=40", idx);
        end
        for (int i = 0; i < 40; i++) exp_stp[319-8*i -: 8] = tx_bytes[i];
        checks++;
        if (perm_start !== 1'b1) begin
            failures++;
            $display("FAIL perm_start_latency got=%b want=1", perm_start);
        end
        checks++;
        if (state_to_perm !== exp_stp) begin
            failures++;
            $display("FAIL state_to_perm got=%h want=%h", state_to_perm, exp_stp);
        end
        checks++;
        if (start_count != starts0) begin
            failures++;
            $display("FAIL early_start got=%0d want=%0d", start_count, starts0);
        end
    endtask

    // Called at the negedge where START is active; returns at the negedge after the 40th output beat.
    task automatic recv_bytes(input int ready_pct, input bit hold, input bit stray);
        int idx;
        int cyc;
        int starts0;
        int ir_seen;
        bit stall_prev;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        idx = 0;
        cyc = 0;
        ir_seen = 0;
        stall_prev = 1'b0;
        prev_data = 8'h00;
        starts0 = start_count;
        while (idx < 40 && cyc < 400) begin
            if (hold) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            if (in_ready) ir_seen++;
            stray_done = stray && (idx == 10) && out_valid;
            out_ready  = ($urandom_range(99) < ready_pct);
            if (stall_prev && out_valid) begin
                checks++;
                if (out_data !== prev_data) begin
                    failures++;
                    $display("FAIL out_stable idx=%0d got=%h want=%h", idx, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                exp_b = tx_bytes[idx] ^ mask_bytes[idx];
                checks++;
                if (out_data !== exp_b) begin
                    failures++;
                    $display("FAIL out_byte idx=%0d got=%h want=%h", idx, out_data, exp_b);
                end
                idx++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
            cyc++;
        end
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        stray_done = 1'b0;
        checks++;
        if (idx != 40) begin
            failures++;
            $display("FAIL unload_timeout beats=%0d required=40", idx);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_load out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
        end
        checks++;
        if (ir_seen != 0) begin
            failures++;
            $display("FAIL in_ready_while_busy cycles=%0d want=0", ir_seen);
        end
        checks++;
        if (start_count != starts0 + 1) begin
            failures++;
            $display("FAIL start_count got=%0d want=%0d", start_count, starts0 + 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || perm_start !== 1'b0 ||
            out_data !== 8'h00 || state_to_perm !== 320'h0) begin
            failures++;
            $display("FAIL %s in_ready=%b busy=%b out_valid=%b perm_start=%b out_data=%h stp_nonzero=%b want 1/0/0/0/00/0",
                     tag, in_ready, busy, out_valid, perm_start, out_data, |state_to_perm);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_load_order;
        set_tx(1'b1);
        set_mask(1'b1);
        send_bytes(100, 1'b0, 1'b0);
        recv_bytes(100, 1'b0, 1'b0);
        $display("txn load_order/loopback done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_midload;
        set_tx(1'b0);
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = tx_bytes[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midload_busy got=%b want=1", busy);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_tx(1'b0);
        set_mask(1'b0);
        send_bytes(100, 1'b0, 1'b0);
        recv_bytes(100, 1'b0, 1'b0);
        $display("txn reset_midload done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_backpressure;
        set_tx(1'b0);
        set_mask(1'b0);
        send_bytes(100, 1'b0, 1'b0);
        recv_bytes(50, 1'b0, 1'b0);
        $display("txn backpressure done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_bubbles_stray;
        set_tx(1'b0);
        set_mask(1'b0);
        send_bytes(60, 1'b1, 1'b1);
        recv_bytes(70, 1'b1, 1'b1);
        $display("txn bubbles_stray done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back;
        set_tx(1'b0);
        set_mask(1'b0);
        send_bytes(100, 1'b0, 1'b0);
        recv_bytes(100, 1'b0, 1'b0);
        set_tx(1'b0);
        set_mask(1'b0);
        send_bytes(100, 1'b0, 1'b0);
        recv_bytes(100, 1'b0, 1'b0);
        $display("txn back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        stray_done = 1'b0;
        mask_vec   = '0;
        @(negedge clk);
        test_reset();
        test_load_order();
        test_reset_midload();
        test_backpressure();
        test_bubbles_stray();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
